// File: rtl/kgp_risc_processor_if.sv
// Observation bus of the KGP-RISC core: last write-back index, last ALU result, current PC.
interface kgp_risc_processor_if;
  logic [4:0]  write_addr;
  logic [31:0] ALUres;
  logic [31:0] finalPC;

  modport master (output write_addr, output ALUres, output finalPC);
  modport slave  (input  write_addr, input  ALUres, input  finalPC);
endinterface

// File: rtl/kgp_risc_processor.sv
// Single-cycle 32-bit KGP-RISC core: ROM fetch, decode, execute and write-back on every clka edge.
// The program ROM image is supplied through IMEM_INIT (word i at bits [32*i+31:32*i]).
module kgp_risc_processor #(
  parameter int                        IMEM_WORDS = 256,
  parameter int                        DMEM_WORDS = 256,
  parameter logic [IMEM_WORDS*32-1:0]  IMEM_INIT  = '0
) (
  input  logic                     clka,
  input  logic                     reset,
  input  logic                     f_clka,
  kgp_risc_processor_if.master     obs
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDI = 6'h01, OP_COMPI = 6'h02, OP_LW  = 6'h03,
                         OP_SW    = 6'h04, OP_BR   = 6'h05, OP_BLTZ  = 6'h06, OP_BZ  = 6'h07,
                         OP_BNZ   = 6'h08, OP_B    = 6'h09, OP_BL    = 6'h0A, OP_BCY = 6'h0B,
                         OP_BNCY  = 6'h0C, OP_HALT = 6'h3F;
  localparam logic [5:0] F_ADD = 6'h00, F_COMP = 6'h01, F_AND = 6'h02, F_XOR = 6'h03,
                         F_SHLL = 6'h04, F_SHRL = 6'h05, F_SHLLV = 6'h06, F_SHRLV = 6'h07,
                         F_SHRA = 6'h08, F_SHRAV = 6'h09;

  logic [31:0] pc_r;
  logic [31:0] regs_r [32];
  logic [31:0] dmem_r [DMEM_WORDS];
  logic        carry_r;
  logic [4:0]  wa_r;
  logic [31:0] res_r;

  logic [IA-1:0] pc_idx_s;
  logic [31:0]   instr_s;
  logic [5:0]    op_s, funct_s;
  logic [4:0]    rs_idx_s, rt_idx_s, shamt_s;
  logic [31:0]   rs_val_s, rt_val_s, imm_s;
  logic [31:0]   pc_plus4_s, br_tgt_s, jmp_tgt_s, ea_s;
  logic [32:0]   add_rr_s, add_ri_s;
  logic [DA-1:0] dm_idx_s;

  logic          rf_we_s, carry_we_s, carry_d_s, dm_we_s;
  logic [4:0]    rf_wa_s, out_wa_s;
  logic [31:0]   rf_wd_s, next_pc_s, out_res_s;
  logic          unused_s;

  // The legacy fast clock pin has no function in this core.
  assign unused_s = f_clka;

  assign pc_idx_s   = pc_r[IA+1:2];
  assign instr_s    = IMEM_INIT[{pc_idx_s, 5'b00000} +: 32];
  assign op_s       = instr_s[31:26];
  assign rs_idx_s   = instr_s[25:21];
  assign rt_idx_s   = instr_s[20:16];
  assign shamt_s    = instr_s[15:11];
  assign funct_s    = instr_s[5:0];
  assign rs_val_s   = regs_r[rs_idx_s];
  assign rt_val_s   = regs_r[rt_idx_s];
  assign imm_s      = {{16{instr_s[15]}}, instr_s[15:0]};
  assign pc_plus4_s = pc_r + 32'd4;
  assign br_tgt_s   = pc_plus4_s + {imm_s[29:0], 2'b00};
  assign jmp_tgt_s  = {4'b0000, instr_s[25:0], 2'b00};
  assign ea_s       = rs_val_s + imm_s;
  assign dm_idx_s   = ea_s[DA+1:2];
  assign add_rr_s   = {1'b0, rs_val_s} + {1'b0, rt_val_s};
  assign add_ri_s   = {1'b0, rs_val_s} + {1'b0, imm_s};

  // Decode and execute the fetched instruction; everything written here lands on the next edge.
  always_comb begin
    rf_we_s    = 1'b0;
    rf_wa_s    = rs_idx_s;
    rf_wd_s    = 32'd0;
    carry_we_s = 1'b0;
    carry_d_s  = 1'b0;
    dm_we_s    = 1'b0;
    next_pc_s  = pc_plus4_s;
    out_wa_s   = 5'd0;
    out_res_s  = 32'd0;
    case (op_s)
      OP_RTYPE: begin
        rf_we_s = 1'b1;
        case (funct_s)
          F_ADD: begin
            rf_wd_s    = add_rr_s[31:0];
            carry_we_s = 1'b1;
            carry_d_s  = add_rr_s[32];
          end
          F_COMP:  rf_wd_s = 32'd0 - rt_val_s;
          F_AND:   rf_wd_s = rs_val_s & rt_val_s;
          F_XOR:   rf_wd_s = rs_val_s ^ rt_val_s;
          F_SHLL:  rf_wd_s = rs_val_s << shamt_s;
          F_SHRL:  rf_wd_s = rs_val_s >> shamt_s;
          F_SHLLV: rf_wd_s = rs_val_s << rt_val_s[4:0];
          F_SHRLV: rf_wd_s = rs_val_s >> rt_val_s[4:0];
          F_SHRA:  rf_wd_s = $signed(rs_val_s) >>> shamt_s;
          F_SHRAV: rf_wd_s = $signed(rs_val_s) >>> rt_val_s[4:0];
          default: rf_we_s = 1'b0;
        endcase
        out_wa_s  = rf_we_s ? rs_idx_s : 5'd0;
        out_res_s = rf_we_s ? rf_wd_s : 32'd0;
      end
      OP_ADDI: begin
        rf_we_s    = 1'b1;
        rf_wd_s    = add_ri_s[31:0];
        carry_we_s = 1'b1;
        carry_d_s  = add_ri_s[32];
        out_wa_s   = rs_idx_s;
        out_res_s  = add_ri_s[31:0];
      end
      OP_COMPI: begin
        rf_we_s   = 1'b1;
        rf_wd_s   = 32'd0 - imm_s;
        out_wa_s  = rs_idx_s;
        out_res_s = 32'd0 - imm_s;
      end
      OP_LW: begin
        rf_we_s   = 1'b1;
        rf_wa_s   = rt_idx_s;
        rf_wd_s   = dmem_r[dm_idx_s];
        out_wa_s  = rt_idx_s;
        out_res_s = ea_s;
      end
      OP_SW: begin
        dm_we_s   = 1'b1;
        out_res_s = ea_s;
      end
      OP_BR:   next_pc_s = rs_val_s;
      OP_BLTZ: next_pc_s = rs_val_s[31] ? br_tgt_s : pc_plus4_s;
      OP_BZ:   next_pc_s = (rs_val_s == 32'd0) ? br_tgt_s : pc_plus4_s;
      OP_BNZ:  next_pc_s = (rs_val_s != 32'd0) ? br_tgt_s : pc_plus4_s;
      OP_B:    next_pc_s = jmp_tgt_s;
      OP_BL: begin
        rf_we_s   = 1'b1;
        rf_wa_s   = 5'd31;
        rf_wd_s   = pc_plus4_s;
        next_pc_s = jmp_tgt_s;
        out_wa_s  = 5'd31;
        out_res_s = pc_plus4_s;
      end
      OP_BCY:  next_pc_s = carry_r ? jmp_tgt_s : pc_plus4_s;
      OP_BNCY: next_pc_s = carry_r ? pc_plus4_s : jmp_tgt_s;
      OP_HALT: next_pc_s = pc_r;
      default: next_pc_s = pc_plus4_s;
    endcase
  end

  // PC, carry flag and observation registers.
  always_ff @(posedge clka) begin
    if (reset) begin
      pc_r    <= 32'd0;
      carry_r <= 1'b0;
      wa_r    <= 5'd0;
      res_r   <= 32'd0;
    end else begin
      pc_r  <= next_pc_s;
      wa_r  <= out_wa_s;
      res_r <= out_res_s;
      if (carry_we_s) begin
        carry_r <= carry_d_s;
      end
    end
  end

  // Register file: cleared by reset, one write port.
  always_ff @(posedge clka) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
    end else if (rf_we_s) begin
      regs_r[rf_wa_s] <= rf_wd_s;
    end
  end

  // Data RAM keeps its contents across reset; reset only suppresses a pending store.
  always_ff @(posedge clka) begin
    if (!reset && dm_we_s) begin
      dmem_r[dm_idx_s] <= rt_val_s;
    end
  end

  assign obs.write_addr = wa_r;
  assign obs.ALUres     = res_r;
  assign obs.finalPC    = pc_r;
endmodule

// File: tb/tb_kgp_risc_processor.sv
// Bench for kgp_risc_processor: an instruction-level interpreter predicts the outputs every cycle,
// and a table of hand-traced values pins both the interpreter and the DUT at key points.
module tb_kgp_risc_processor;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] sh, input logic [5:0] fn);
    return {6'h00, rs, rt, sh, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  function automatic logic [8191:0] build_prog();
    logic [8191:0] p;
    p = '0;
    p[ 0*32 +: 32] = enc_i(6'h01, 5'd1, 5'd0, 16'd5);        // addi r1,5
    p[ 1*32 +: 32] = enc_i(6'h01, 5'd2, 5'd0, 16'hFFFD);     // addi r2,-3
    p[ 2*32 +: 32] = enc_r(5'd1, 5'd2, 5'd0, 6'h00);         // add r1,r2
    p[ 3*32 +: 32] = enc_i(6'h04, 5'd0, 5'd2, 16'd8);        // sw r2,8(r0)
    p[ 4*32 +: 32] = enc_i(6'h07, 5'd0, 5'd0, 16'd2);        // bz r0,+2
    p[ 5*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd1);
    p[ 6*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd2);
    p[ 7*32 +: 32] = enc_i(6'h03, 5'd0, 5'd4, 16'd8);        // lw r4,8(r0)
    p[ 8*32 +: 32] = enc_j(6'h0A, 26'h40);                   // bl 0x40
    p[ 9*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd3);
    p[10*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd4);
    p[11*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd5);
    p[12*32 +: 32] = {6'h3F, 26'd0};                          // halt
    p[64*32 +: 32] = enc_i(6'h01, 5'd1, 5'd0, 16'hFFFE);     // addi r1,-2
    p[65*32 +: 32] = enc_i(6'h01, 5'd1, 5'd0, 16'd1);        // addi r1,1
    p[66*32 +: 32] = enc_r(5'd1, 5'd0, 5'd31, 6'h04);        // shll r1,31
    p[67*32 +: 32] = enc_r(5'd7, 5'd1, 5'd0, 6'h00);         // add r7,r1
    p[68*32 +: 32] = enc_r(5'd3, 5'd1, 5'd0, 6'h01);         // comp r3,r1
    p[69*32 +: 32] = enc_r(5'd1, 5'd0, 5'd4, 6'h08);         // shra r1,4
    p[70*32 +: 32] = enc_r(5'd7, 5'd0, 5'd4, 6'h05);         // shrl r7,4
    p[71*32 +: 32] = enc_r(5'd3, 5'd1, 5'd0, 6'h03);         // xor r3,r1
    p[72*32 +: 32] = enc_r(5'd7, 5'd3, 5'd0, 6'h02);         // and r7,r3
    p[73*32 +: 32] = enc_i(6'h02, 5'd8, 5'd0, 16'hFFFC);     // compi r8,-4
    p[74*32 +: 32] = enc_r(5'd7, 5'd8, 5'd0, 6'h06);         // shllv r7,r8
    p[75*32 +: 32] = enc_r(5'd7, 5'd8, 5'd0, 6'h09);         // shrav r7,r8
    p[76*32 +: 32] = enc_r(5'd7, 5'd8, 5'd0, 6'h07);         // shrlv r7,r8
    p[77*32 +: 32] = enc_i(6'h01, 5'd9, 5'd0, 16'hFFFF);     // addi r9,-1
    p[78*32 +: 32] = enc_i(6'h01, 5'd9, 5'd0, 16'd1);        // addi r9,1 (carry out)
    p[79*32 +: 32] = enc_j(6'h0B, 26'h51);                   // bcy 0x51
    p[80*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd6);
    p[81*32 +: 32] = enc_j(6'h0C, 26'h7F);                   // bncy (not taken)
    p[82*32 +: 32] = enc_i(6'h06, 5'd1, 5'd0, 16'd1);        // bltz r1,+1
    p[83*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd7);
    p[84*32 +: 32] = enc_i(6'h08, 5'd0, 5'd0, 16'd5);        // bnz r0 (not taken)
    p[85*32 +: 32] = enc_i(6'h01, 5'd10, 5'd0, 16'h0160);    // addi r10,0x160
    p[86*32 +: 32] = enc_i(6'h05, 5'd10, 5'd0, 16'd0);       // br r10
    p[87*32 +: 32] = enc_i(6'h01, 5'd5, 5'd0, 16'd9);
    p[88*32 +: 32] = enc_i(6'h10, 5'd6, 5'd6, 16'h1234);     // unknown opcode
    p[89*32 +: 32] = enc_r(5'd6, 5'd6, 5'd0, 6'h2A);         // unknown funct
    p[90*32 +: 32] = enc_i(6'h04, 5'd0, 5'd1, 16'h03FC);     // sw r1,0x3FC(r0)
    p[91*32 +: 32] = enc_i(6'h03, 5'd0, 5'd12, 16'hFFFC);    // lw r12,-4(r0)
    p[92*32 +: 32] = enc_r(5'd12, 5'd12, 5'd0, 6'h00);       // add r12,r12
    p[93*32 +: 32] = enc_j(6'h0C, 26'd0);                    // bncy (not taken)
    p[94*32 +: 32] = enc_i(6'h01, 5'd13, 5'd0, 16'h0030);    // addi r13,0x30
    p[95*32 +: 32] = enc_i(6'h05, 5'd13, 5'd0, 16'd0);       // br r13 -> halt
    return p;
  endfunction

  localparam logic [8191:0] PROG = build_prog();

  logic clka = 1'b0;
  logic f_clka = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  logic chk_en = 1'b0;

  kgp_risc_processor_if obs_if ();

  kgp_risc_processor #(.IMEM_WORDS(256), .DMEM_WORDS(256), .IMEM_INIT(PROG)) dut (
    .clka   (clka),
    .reset  (reset),
    .f_clka (f_clka),
    .obs    (obs_if)
  );

  always #5 clka = ~clka;
  always #3 f_clka = ~f_clka;

  // Reference interpreter state
  logic [31:0] prog   [256];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [256];
  logic [31:0] m_pc, m_res;
  logic [4:0]  m_wa;
  logic        m_carry;

  initial for (int i = 0; i < 256; i++) prog[i] = PROG[i*32 +: 32];

  task automatic model_step(input logic rst);
    logic [31:0] ins, a, b, imm, v, npc, jt;
    logic [4:0]  s, t, sh;
    logic [63:0] wide;
    logic        wr;
    if (rst) begin
      m_pc = 32'd0; m_carry = 1'b0; m_wa = 5'd0; m_res = 32'd0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    end else begin
      ins = prog[m_pc[9:2]];
      s = ins[25:21]; t = ins[20:16]; sh = ins[15:11];
      a = m_regs[s]; b = m_regs[t];
      imm = {{16{ins[15]}}, ins[15:0]};
      jt = {4'b0000, ins[25:0], 2'b00};
      npc = m_pc + 32'd4;
      m_wa = 5'd0; m_res = 32'd0; v = 32'd0; wr = 1'b1;
      case (ins[31:26])
        6'h00: begin
          case (ins[5:0])
            6'd0: begin wide = {32'd0, a} + {32'd0, b}; v = wide[31:0]; m_carry = wide[32]; end
            6'd1: v = 32'd0 - b;
            6'd2: v = a & b;
            6'd3: v = a ^ b;
            6'd4: v = a << sh;
            6'd5: v = a >> sh;
            6'd6: v = a << b[4:0];
            6'd7: v = a >> b[4:0];
            6'd8: v = $signed(a) >>> sh;
            6'd9: v = $signed(a) >>> b[4:0];
            default: wr = 1'b0;
          endcase
          if (wr) begin m_regs[s] = v; m_wa = s; m_res = v; end
        end
        6'h01: begin
          wide = {32'd0, a} + {32'd0, imm}; m_carry = wide[32];
          m_regs[s] = wide[31:0]; m_wa = s; m_res = wide[31:0];
        end
        6'h02: begin m_regs[s] = 32'd0 - imm; m_wa = s; m_res = 32'd0 - imm; end
        6'h03: begin m_res = a + imm; m_regs[t] = m_dmem[m_res[9:2]]; m_wa = t; end
        6'h04: begin m_res = a + imm; m_dmem[m_res[9:2]] = b; end
        6'h05: npc = a;
        6'h06: if ($signed(a) < 0) npc = m_pc + 32'd4 + (imm << 2);
        6'h07: if (a == 32'd0) npc = m_pc + 32'd4 + (imm << 2);
        6'h08: if (a != 32'd0) npc = m_pc + 32'd4 + (imm << 2);
        6'h09: npc = jt;
        6'h0A: begin m_regs[31] = npc; m_wa = 5'd31; m_res = npc; npc = jt; end
        6'h0B: if (m_carry) npc = jt;
        6'h0C: if (!m_carry) npc = jt;
        6'h3F: npc = m_pc;
        default: ;
      endcase
      m_pc = npc;
    end
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(posedge clka) begin
    model_step(reset);
    chk_en = 1'b1;
  end

  // Every-cycle comparison of the DUT against the interpreter
  always @(negedge clka) begin
    if (chk_en) begin
      cmp("finalPC", obs_if.finalPC, m_pc);
      cmp("ALUres", obs_if.ALUres, m_res);
      cmp("write_addr", {27'd0, obs_if.write_addr}, {27'd0, m_wa});
    end
  end

  // Hand-traced expectations: edge number after reset release, PC, write_addr, ALUres
  int          pin_edge [17] = '{1, 2, 3, 4, 5, 6, 7, 12, 13, 14, 20, 25, 28, 32, 33, 36, 46};
  logic [31:0] pin_pc   [17] = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h1C, 32'h20, 32'h100, 32'h114,
                                 32'h118, 32'h11C, 32'h134, 32'h150, 32'h160, 32'h170, 32'h174,
                                 32'h30, 32'h30};
  logic [4:0]  pin_wa   [17] = '{5'd1, 5'd2, 5'd1, 5'd0, 5'd0, 5'd4, 5'd31, 5'd3, 5'd1, 5'd7,
                                 5'd7, 5'd0, 5'd0, 5'd12, 5'd12, 5'd0, 5'd0};
  logic [31:0] pin_res  [17] = '{32'd5, 32'hFFFFFFFD, 32'd2, 32'd8, 32'd0, 32'd8, 32'h24,
                                 32'h80000000, 32'hF8000000, 32'h08000000, 32'h0F800000, 32'd0,
                                 32'd0, 32'hFFFFFFFC, 32'hF0000000, 32'd0, 32'd0};

  task automatic pin_check(input int e);
    for (int k = 0; k < 17; k++) begin
      if (pin_edge[k] == e) begin
        cmp($sformatf("pin_pc_e%0d", e), obs_if.finalPC, pin_pc[k]);
        cmp($sformatf("pin_wa_e%0d", e), {27'd0, obs_if.write_addr}, {27'd0, pin_wa[k]});
        cmp($sformatf("pin_res_e%0d", e), obs_if.ALUres, pin_res[k]);
        cmp($sformatf("model_pc_e%0d", e), m_pc, pin_pc[k]);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    cmp({tag, "_pc"}, obs_if.finalPC, 32'd0);
    cmp({tag, "_wa"}, {27'd0, obs_if.write_addr}, 32'd0);
    cmp({tag, "_res"}, obs_if.ALUres, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clka);
    @(negedge clka);
    check_reset_state("reset");
    reset = 1'b0;
    for (int e = 1; e <= 46; e++) begin
      @(posedge clka);
      @(negedge clka);
      pin_check(e);
    end
    reset = 1'b1;
    @(posedge clka);
    @(negedge clka);
    check_reset_state("halt_reset");
    reset = 1'b0;
    repeat (3) begin @(posedge clka); @(negedge clka); end
    cmp("pc_before_midreset", obs_if.finalPC, 32'hC);
    reset = 1'b1;
    @(posedge clka);
    @(negedge clka);
    check_reset_state("mid_reset");
    reset = 1'b0;
    repeat (8) begin @(posedge clka); @(negedge clka); end
    cmp("rerun_pc", obs_if.finalPC, 32'h104);
    cmp("rerun_wa", {27'd0, obs_if.write_addr}, 32'd1);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
